// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// Parametrised UART receiver with mid-bit sampling, false-start rejection,
// parity / framing / overrun detection and a one-entry holding register
// with a valid/ack handshake.
//
// Parameters
//   CLK_HZ     system clock frequency in Hz
//   BAUD       line rate; CLKS_PER_BIT = CLK_HZ / BAUD (must be >= 4)
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  stop bits checked, 1 or 2
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx           raw serial line, idle high, asynchronous to clk
//   rx_enable    gates detection of new start bits only
//   rx_data      received word, LSB = first bit on the line
//   rx_valid     holding register full, level until acknowledged
//   rx_ack       consumer accepts rx_data (only while rx_valid = 1)
//   parity_err   parity mismatch for the held word
//   frame_err    a stop bit was sampled low for the held word
//   overrun_err  one-cycle pulse when a completed frame is dropped
//   busy         receiver FSM is not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_frame #(
   parameter int CLK_HZ    = 12000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 rx_enable,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_BITS + 1);
   localparam logic PAR_ODD    = (PARITY == 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_frame: CLK_HZ/BAUD must be at least 4");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_frame: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic                 r_armed;
   logic [CNT_W-1:0]     r_count;
   logic [IDX_W-1:0]     r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_done;

   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_parity_err;
   logic                 r_frame_err;
   logic                 r_overrun_err;

   logic                 w_tick;
   logic                 w_last_data;
   logic                 w_last_stop;
   logic                 w_shift_en;
   logic                 w_par_en;
   logic                 w_stop_en;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // START waits half a bit so every later full-bit sample lands mid-bit.
   assign w_tick      = (r_state == S_START) ? (r_count == CNT_W'(HALF - 1))
                                             : (r_count == CNT_W'(CLKS_PER_BIT - 1));
   assign w_last_data = (r_bit_idx == IDX_W'(DATA_BITS - 1));
   assign w_last_stop = (r_bit_idx == IDX_W'(STOP_BITS - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (rx_enable && r_armed && !r_rx_s) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_tick && w_last_data) begin
               w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               w_state_next = S_STOP;
            end
         end
         S_STOP: begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            if (w_tick && w_last_stop) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output / strobe decode from the state register
   always_comb begin
      busy       = (r_state != S_IDLE);
      w_shift_en = (r_state == S_DATA)   && w_tick;
      w_par_en   = (r_state == S_PARITY) && w_tick;
      w_stop_en  = (r_state == S_STOP)   && w_tick;
   end

   // Bit timing, sampling and per-frame error accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_done    <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         if (r_state == S_IDLE || w_tick) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end

         case (r_state)
            S_DATA: begin
               if (w_tick) begin
                  r_bit_idx <= w_last_data ? '0 : r_bit_idx + IDX_W'(1);
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_bit_idx <= r_bit_idx + IDX_W'(1);
               end
            end
            default: begin
               r_bit_idx <= '0;
            end
         endcase

         if (w_shift_en) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
         end

         if (r_state == S_START) begin
            r_perr <= 1'b0;
         end else if (w_par_en) begin
            r_perr <= (((^r_shift) ^ r_rx_s) != PAR_ODD);
         end

         if (r_state == S_START) begin
            r_ferr <= 1'b0;
         end else if (w_stop_en && !r_rx_s) begin
            r_ferr <= 1'b1;
         end

         r_done <= w_stop_en && w_last_stop;

         // A line still held low after a frame (break) must go high before
         // another start is accepted.
         if (r_state != S_IDLE) begin
            r_armed <= 1'b0;
         end else if (r_rx_s) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Holding register with valid/ack handshake and overrun detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_parity_err  <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_overrun_err <= 1'b0;
         if (r_done) begin
            if (!r_rx_valid || rx_ack) begin
               r_rx_data    <= r_shift;
               r_parity_err <= r_perr;
               r_frame_err  <= r_ferr;
               r_rx_valid   <= 1'b1;
            end else begin
               r_overrun_err <= 1'b1;
            end
         end else if (rx_ack && r_rx_valid) begin
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
         end
      end
   end

   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign parity_err  = r_parity_err;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun_err;

endmodule
